// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, mouse command bytes, parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        XFER,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] PS2_ACK_BYTE     = 8'hFA;

    // Data bits plus parity plus stop.
    localparam int FRAME_BITS = 10;

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one PS/2 line plus falling-edge detect.
// Flops reset to 1 because an idle PS/2 line is pulled high.
module ps2_line_sync (
    input  logic clock,
    input  logic reset,
    input  logic line,
    output logic synced,
    output logic fall
);

    logic meta;
    logic prev;

    // Metastability stage, synced value, and its one-cycle history.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta   <= 1'b1;
            synced <= 1'b1;
            prev   <= 1'b1;
        end else begin
            meta   <= line;
            synced <= meta;
            prev   <= synced;
        end
    end

    assign fall = prev & ~synced;

endmodule

// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 8 data bits + odd parity
// + stop clocked by the device, then ACK check and wait for the bus to idle.
module ps2_command_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES    = 5500,
    parameter int START_HOLD_CYCLES = 50,
    parameter int TIMEOUT_CYCLES    = 750000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] command,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int MAX_A = (INHIBIT_CYCLES > START_HOLD_CYCLES) ? INHIBIT_CYCLES : START_HOLD_CYCLES;
    localparam int MAX_P = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CW    = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(START_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);

    ps2_state_e            state, state_next;
    logic [CW-1:0]         cnt, cnt_next;
    logic [3:0]            n, n_next;
    logic [FRAME_BITS-1:0] frame, frame_next;
    logic                  clk_low, clk_low_next;
    logic                  dat_low, dat_low_next;
    logic                  done_next, error_next;

    logic clk_s, clk_fall;
    logic dat_s, dat_fall;

    // Open-drain drivers: only ever pull low or let go.
    assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

    ps2_line_sync u_clk_sync (
        .clock  (clock),
        .reset  (reset),
        .line   (PS2_CLK),
        .synced (clk_s),
        .fall   (clk_fall)
    );

    ps2_line_sync u_dat_sync (
        .clock  (clock),
        .reset  (reset),
        .line   (PS2_DAT),
        .synced (dat_s),
        .fall   (dat_fall)
    );

    // Busy drops in the same cycle done/error pulses since those are
    // registered alongside the return to IDLE.
    assign busy = (state != IDLE);

    // State, counters, frame and registered line drives / pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            n       <= '0;
            frame   <= '0;
            clk_low <= 1'b0;
            dat_low <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            n       <= n_next;
            frame   <= frame_next;
            clk_low <= clk_low_next;
            dat_low <= dat_low_next;
            done    <= done_next;
            error   <= error_next;
        end
    end

    // Next-state logic; counter doubles as phase timer and fall-to-fall timeout.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        n_next       = n;
        frame_next   = frame;
        clk_low_next = clk_low;
        dat_low_next = dat_low;
        done_next    = 1'b0;
        error_next   = 1'b0;

        case (state)
            IDLE: begin
                if (send) begin
                    frame_next   = {1'b1, odd_parity(command), command};
                    state_next   = INHIBIT;
                    clk_low_next = 1'b1;
                    cnt_next     = '0;
                    n_next       = '0;
                end
            end
            INHIBIT: begin
                if (cnt == INH_LAST) begin
                    state_next   = START;
                    dat_low_next = 1'b1;
                    cnt_next     = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            START: begin
                if (cnt == HOLD_LAST) begin
                    state_next   = XFER;
                    clk_low_next = 1'b0;
                    cnt_next     = '0;
                    n_next       = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            XFER, ACK, WAIT_IDLE: begin
                cnt_next = clk_fall ? '0 : cnt + 1'b1;
                if (!clk_fall && cnt == TO_LAST) begin
                    state_next   = IDLE;
                    clk_low_next = 1'b0;
                    dat_low_next = 1'b0;
                    error_next   = 1'b1;
                end else if (state == XFER && clk_fall) begin
                    // Fall k presents frame bit k-1; the 10th is the stop bit.
                    n_next       = n + 4'd1;
                    dat_low_next = ~frame[n];
                    if (n == 4'(FRAME_BITS - 1))
                        state_next = ACK;
                end else if (state == ACK && clk_fall) begin
                    if (dat_s) begin
                        error_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = WAIT_IDLE;
                    end
                end else if (state == WAIT_IDLE && clk_s && dat_s) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ps2_command_tx.sv
// Directed bench for ps2_command_tx with a behavioural PS/2 device model.
module tb_ps2_command_tx;
    import ps2_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       send = 1'b0;
    logic [7:0] command = 8'h00;
    logic       busy, done, error;
    wire        ps2_clk, ps2_dat;

    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic [9:0] dev_frame;

    int tests = 0, fails = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    logic busy_at_done = 1'b1, busy_at_err = 1'b1;

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

    ps2_command_tx #(
        .INHIBIT_CYCLES    (20),
        .START_HOLD_CYCLES (5),
        .TIMEOUT_CYCLES    (400)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .send    (send),
        .command (command),
        .PS2_CLK (ps2_clk),
        .PS2_DAT (ps2_dat),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    always @(negedge clock) begin
        if (done) begin done_cnt++; busy_at_done = busy; end
        if (error) begin err_cnt++; busy_at_err = busy; end
        if (done && error) both_cnt++;
    end

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] cmd2;
        bit         resend;
        logic [9:0] frame;   // {stop, parity, d7..d0} as the device should see it
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_send(input logic [7:0] c);
        @(negedge clock);
        send = 1'b1;
        command = c;
        @(negedge clock);
        send = 1'b0;
    endtask

    // Count inhibit-only and start-bit cycles until the host releases the clock.
    task automatic wait_rts(output int inh, output int hold, output bit ok);
        inh = 0; hold = 0; ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (ps2_clk === 1'b1 && ps2_dat === 1'b0) begin ok = 1'b1; break; end
            if (ps2_clk === 1'b0 && ps2_dat === 1'b1) inh++;
            if (ps2_clk === 1'b0 && ps2_dat === 1'b0) hold++;
            @(negedge clock);
        end
    endtask

    // Device clock pulses first..last (period 40 system cycles); samples data on rise.
    task automatic dev_pulses(input int first, input int last, input bit ack);
        for (int k = first; k <= last; k++) begin
            repeat (10) @(negedge clock);
            if (k == 11 && ack) dev_dat_low = 1'b1;
            repeat (10) @(negedge clock);
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clock);
            dev_clk_low = 1'b0;
            #1;
            if (k <= 10) dev_frame[k-1] = ps2_dat;
        end
        if (ack && last == 11) begin
            repeat (5) @(negedge clock);
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic wait_outcome(input int d0, input int e0, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done_cnt != d0 || err_cnt != e0) begin seen = 1'b1; break; end
            @(negedge clock);
            #1;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int  d0, e0, inh, hold;
        bit  ok, seen;
        string t;
        t = $sformatf("cmd%02h", v.cmd);
        d0 = done_cnt; e0 = err_cnt;
        dev_frame = '0;
        do_send(v.cmd);
        check({t, "_busy_rise"}, 32'(busy), 1);
        if (v.resend) begin
            fork
                wait_rts(inh, hold, ok);
                begin
                    @(negedge clock);
                    send = 1'b1;
                    command = v.cmd2;
                    @(negedge clock);
                    send = 1'b0;
                end
            join
        end else begin
            wait_rts(inh, hold, ok);
        end
        check({t, "_rts_seen"}, 32'(ok), 1);
        check({t, "_inhibit_cycles"}, inh, 20);
        check({t, "_start_hold_cycles"}, hold, 5);
        dev_pulses(1, 11, 1'b1);
        wait_outcome(d0, e0, seen);
        check({t, "_outcome_seen"}, 32'(seen), 1);
        check({t, "_frame"}, 32'(dev_frame), 32'(v.frame));
        check({t, "_done_pulses"}, done_cnt - d0, 1);
        check({t, "_error_pulses"}, err_cnt - e0, 0);
        check({t, "_busy_at_done"}, 32'(busy_at_done), 0);
        check({t, "_busy_after"}, 32'(busy), 0);
    endtask

    initial begin
        int  d0, e0, inh, hold, k;
        bit  ok, seen;
        vec_t v;

        // Hand-computed frames: parity = 1 when the byte has an even count of ones.
        vecs[0] = '{cmd: 8'hF4, cmd2: 8'h00, resend: 1'b0, frame: 10'h2F4}; // 5 ones -> p=0
        vecs[1] = '{cmd: 8'hFF, cmd2: 8'h00, resend: 1'b0, frame: 10'h3FF}; // 8 ones -> p=1
        vecs[2] = '{cmd: 8'h00, cmd2: 8'hAA, resend: 1'b1, frame: 10'h300}; // 0 ones -> p=1; AA ignored
        vecs[3] = '{cmd: 8'h80, cmd2: 8'h00, resend: 1'b0, frame: 10'h280}; // 1 one  -> p=0

        // Reset state.
        repeat (3) @(negedge clock);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_error", 32'(error), 0);
        check("reset_clk_released", 32'(ps2_clk), 1);
        check("reset_dat_released", 32'(ps2_dat), 1);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i]);
            repeat (10) @(negedge clock);
        end

        // Device never clocks: timeout 400 cycles after the clock release.
        d0 = done_cnt; e0 = err_cnt;
        do_send(8'h55);
        wait_rts(inh, hold, ok);
        check("to_rts_seen", 32'(ok), 1);
        k = 0;
        for (int i = 1; i <= 500; i++) begin
            @(negedge clock);
            if (error === 1'b1) begin k = i; break; end
        end
        check("to_error_delay", k, 400);
        check("to_clk_released", 32'(ps2_clk), 1);
        check("to_dat_released", 32'(ps2_dat), 1);
        check("to_busy", 32'(busy), 0);
        repeat (5) @(negedge clock);
        check("to_error_pulses", err_cnt - e0, 1);
        check("to_done_pulses", done_cnt - d0, 0);
        repeat (10) @(negedge clock);

        // Device leaves the ACK slot high.
        d0 = done_cnt; e0 = err_cnt;
        dev_frame = '0;
        do_send(8'h01);
        wait_rts(inh, hold, ok);
        check("nack_rts_seen", 32'(ok), 1);
        dev_pulses(1, 10, 1'b0);
        check("nack_no_early_error", err_cnt - e0, 0);
        dev_pulses(11, 11, 1'b0);
        wait_outcome(d0, e0, seen);
        check("nack_outcome_seen", 32'(seen), 1);
        check("nack_frame", 32'(dev_frame), 32'h201);
        check("nack_error_pulses", err_cnt - e0, 1);
        check("nack_done_pulses", done_cnt - d0, 0);
        check("nack_busy_at_error", 32'(busy_at_err), 0);
        repeat (10) @(negedge clock);

        // Reset after the 4th falling edge (host is driving d3=0 of 0xF4).
        d0 = done_cnt; e0 = err_cnt;
        do_send(PS2_CMD_ENABLE);
        wait_rts(inh, hold, ok);
        check("rst_rts_seen", 32'(ok), 1);
        dev_pulses(1, 4, 1'b0);
        check("rst_d3_driven_low", 32'(ps2_dat), 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_clk_released", 32'(ps2_clk), 1);
        check("rst_dat_released", 32'(ps2_dat), 1);
        check("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        repeat (50) @(negedge clock);
        check("rst_no_done", done_cnt - d0, 0);
        check("rst_no_error", err_cnt - e0, 0);

        // Normal transfer after the aborted one: 0xF3 has 6 ones -> p=1.
        v = '{cmd: PS2_CMD_SET_RATE, cmd2: 8'h00, resend: 1'b0, frame: 10'h3F3};
        run_vec(v);

        check("never_done_and_error", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ps2_command_tx.md
Name: ps2_command_tx

Overview:
Host-to-device PS/2 transmitter; sends one command byte to the mouse (e.g. 0xF4 enable reporting, 0xFF reset) over the same PS2_CLK/PS2_DAT lines the mouse tracker listens on. Generates the inhibit/request-to-send sequence, shifts 8 data bits plus odd parity and stop on device clock edges, and checks the device ACK. Sits beside mouse_tracker at the top level; the tracker ignores traffic while busy=1.

Parameters:
INHIBIT_CYCLES, 5500, clock cycles PS2_CLK is held low before the start bit (110 us at 50 MHz)
START_HOLD_CYCLES, 50, cycles PS2_DAT and PS2_CLK are both held low before PS2_CLK is released
TIMEOUT_CYCLES, 750000, maximum cycles between device clock falling edges (15 ms at 50 MHz)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
send  input  1  one-cycle request; accepted only when busy=0
command  input  8  byte to transmit; latched on an accepted send
PS2_CLK  inout  1  open-drain: drive 0 or Z only
PS2_DAT  inout  1  open-drain: drive 0 or Z only
busy  output  1  high from the cycle after an accepted send until done/error
done  output  1  one-cycle pulse: byte sent and ACK received
error  output  1  one-cycle pulse: timeout or missing ACK

Behaviour:
- Reset (synchronous, active-high): state IDLE; busy=0, done=0, error=0; both lines released (Z) at the next edge, including mid-transfer. Counters and the shift register are cleared.
- Line input: PS2_CLK and PS2_DAT each pass through a 2-flop synchroniser. fall_clk = previous synced value 1 and current synced value 0.
- Parity: odd, computed as the XNOR-reduce of the latched byte. Frame is d0..d7 LSB first, then parity, then stop=1.
- IDLE: on send=1, latch command and parity, go to INHIBIT, busy=1. A send while busy=1 is ignored and leaves the latched byte unchanged.
- INHIBIT: drive PS2_CLK=0 for exactly INHIBIT_CYCLES cycles, then go to START.
- START: keep PS2_CLK=0 and drive PS2_DAT=0 (start bit) for START_HOLD_CYCLES cycles. Then release PS2_CLK, clear the bit counter and the timeout counter, and go to XFER.
- XFER: on each fall_clk, bit counter n increments.
  - n=1..8: present d[n-1] on PS2_DAT (1 means release).
  - n=9: present parity.
  - n=10: release PS2_DAT (stop bit) and go to ACK.
  - Data changes only on fall_clk.
- ACK: on the next fall_clk, sample synced PS2_DAT.
  - Sampled 0: go to WAIT_IDLE.
  - Sampled 1: pulse error, go to IDLE.
- WAIT_IDLE: when synced PS2_CLK and PS2_DAT are both 1, pulse done, go to IDLE, busy=0 in the same cycle as done.
- Timeout: in XFER, ACK and WAIT_IDLE, the counter resets on every fall_clk. On reaching TIMEOUT_CYCLES: release both lines, pulse error, go to IDLE.
- done and error are never high together. busy falls in the same cycle as either pulse.
- Counter widths: $clog2 of the largest parameter, +1.

Decomposition:
- Shared package ps2_pkg:
  - state enum (IDLE, INHIBIT, START, XFER, ACK, WAIT_IDLE)
  - command constants: PS2_CMD_RESET=8'hFF, PS2_CMD_ENABLE=8'hF4, PS2_CMD_SET_RATE=8'hF3, PS2_ACK_BYTE=8'hFA
- One sub-module, ps2_line_sync: 2-flop synchroniser plus falling-edge detect. Reused later by the receive path.

Test Plan:
- Bench parameters: INHIBIT_CYCLES=20, START_HOLD_CYCLES=5, TIMEOUT_CYCLES=400. Device model clocks at 1/40 of the system clock and ACKs.
- send with command=8'hF4 -> PS2_CLK low exactly 20 cycles; device samples 0,0,1,0,1,1,1,1, parity 0, stop 1; ACK low -> done pulse, busy=0, error=0.
- send with command=8'hFF -> parity bit sampled as 1; done pulse.
- send with command=8'h00 -> parity bit 1; second send 2 cycles later with 8'hAA -> ignored, device still receives 0x00.
- Device never clocks after release -> error pulse exactly 400 cycles after PS2_CLK release; both lines Z; no done.
- Device holds PS2_DAT high in the ACK slot -> error pulse after the 11th falling edge; busy=0.
- reset asserted after the 4th falling edge -> next cycle: lines Z, busy=0, no done/error. A following send of 8'hF3 completes normally.
